obj_ram_arbiter: RTL

- Arbitrates and sequences access to the single-port 16x32 object RAM that holds the stone/gold/diamond records.
- Requesters are the rope controllers (player 0, player 1) and the object draw engine.
- Ownership is granted round-robin and locked until the owner pulses release, so a read-modify-write sequence is atomic.
- The block generates RAM control, read/write completion pulses and captured read data.

---
 rtl/obj_ram_arbiter.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/obj_ram_arbiter.sv
// Round-robin, ownership-locked arbiter for the single-port 16x32 object RAM.
// The owner keeps the RAM across several accesses until it releases it, so read-modify-write is atomic.
module obj_ram_arbiter #(
  parameter int N_REQ        = 3,
  parameter int RD_LATENCY   = 2,
  parameter int HOLD_TIMEOUT = 1024
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [N_REQ-1:0]      req_read,
  input  logic [N_REQ-1:0]      req_write,
  input  logic [4*N_REQ-1:0]    req_addr,
  input  logic [32*N_REQ-1:0]   req_wdata,
  input  logic [N_REQ-1:0]      req_release,
  output logic [N_REQ-1:0]      grant,
  output logic [N_REQ-1:0]      read_done,
  output logic [N_REQ-1:0]      write_done,
  output logic [31:0]           rd_data,
  output logic [3:0]            ram_addr,
  output logic [31:0]           ram_wdata,
  output logic                  ram_wren,
  input  logic [31:0]           ram_rdata,
  output logic                  forced_release
);

  localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int IW = (HOLD_TIMEOUT > 1) ? $clog2(HOLD_TIMEOUT) : 1;
  localparam logic [IW-1:0] IDLE_LAST = IW'((HOLD_TIMEOUT > 0) ? HOLD_TIMEOUT - 1 : 0);
  // S_RD_WAIT is entered with this count and leaves when it reaches zero
  localparam logic [7:0] WAIT_INIT = 8'((RD_LATENCY > 2) ? RD_LATENCY - 2 : 0);

  typedef enum logic [2:0] {
    S_IDLE, S_OWN, S_RD_WAIT, S_RD_DONE, S_WR, S_WR_DONE, S_HOLDOFF
  } state_t;

  state_t          state;
  logic [OW-1:0]   owner;
  logic [OW-1:0]   rr_last;
  logic [7:0]      wait_cnt;
  logic [IW-1:0]   idle_cnt;

  logic [3:0]      addr_arr  [N_REQ];
  logic [31:0]     wdata_arr [N_REQ];
  logic [N_REQ-1:0] cand;
  logic            pick_found;
  logic [OW-1:0]   pick_idx;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign addr_arr[gi]  = req_addr[4*gi +: 4];
      assign wdata_arr[gi] = req_wdata[32*gi +: 32];
      assign cand[gi]      = req_read[gi] | req_write[gi];
    end
  endgenerate

  // Walk offsets from far to near so the nearest candidate after rr_last wins.
  always_comb begin
    int idx;
    idx        = 0;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = (int'(rr_last) + k) % N_REQ;
      if (cand[idx]) begin
        pick_found = 1'b1;
        pick_idx   = OW'(idx);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= S_IDLE;
      owner          <= '0;
      rr_last        <= OW'(N_REQ - 1);
      wait_cnt       <= '0;
      idle_cnt       <= '0;
      grant          <= '0;
      read_done      <= '0;
      write_done     <= '0;
      rd_data        <= '0;
      ram_addr       <= '0;
      ram_wdata      <= '0;
      ram_wren       <= 1'b0;
      forced_release <= 1'b0;
    end else begin
      read_done      <= '0;
      write_done     <= '0;
      forced_release <= 1'b0;
      ram_wren       <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pick_found) begin
            grant    <= {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx;
            owner    <= pick_idx;
            idle_cnt <= '0;
            state    <= S_OWN;
          end
        end
        S_OWN: begin
          if (req_release[owner]) begin
            grant   <= '0;
            rr_last <= owner;
            state   <= S_IDLE;
          end else if (req_read[owner]) begin
            ram_addr <= addr_arr[owner];
            wait_cnt <= WAIT_INIT;
            idle_cnt <= '0;
            state    <= (RD_LATENCY <= 1) ? S_RD_DONE : S_RD_WAIT;
          end else if (req_write[owner]) begin
            ram_addr  <= addr_arr[owner];
            ram_wdata <= wdata_arr[owner];
            ram_wren  <= 1'b1;
            idle_cnt  <= '0;
            state     <= S_WR;
          end else if (HOLD_TIMEOUT > 0 && idle_cnt == IDLE_LAST) begin
            forced_release <= 1'b1;
            grant          <= '0;
            rr_last        <= owner;
            idle_cnt       <= '0;
            state          <= S_IDLE;
          end else if (HOLD_TIMEOUT > 0) begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        S_RD_WAIT: begin
          if (wait_cnt == 8'd0) state <= S_RD_DONE;
          else                  wait_cnt <= wait_cnt - 8'd1;
        end
        S_RD_DONE: begin
          rd_data   <= ram_rdata;
          read_done <= grant;
          state     <= S_HOLDOFF;
        end
        S_WR: begin
          write_done <= grant;
          state      <= S_WR_DONE;
        end
        S_WR_DONE: state <= S_HOLDOFF;
        S_HOLDOFF: begin
          // requests still asserted from the finished access are deliberately not sampled here
          if (req_release[owner]) begin
            grant   <= '0;
            rr_last <= owner;
            state   <= S_IDLE;
          end else begin
            state <= S_OWN;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
